fp_add_scheduler: RTL and testbench



---
 rtl/fp_add_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one fixed-latency FP32 adder between NUM_REQ requesters.
// Optional macro FP_SCHED_SPECIAL_BYPASS_EN: Inf/NaN operand pairs are resolved locally without the adder.
module fp_add_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADD_LATENCY = 3,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  output logic                  add_start,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_result,
  output logic                  busy
);

  localparam int unsigned CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [31:0]      add_a_q, add_a_d, add_b_q, add_b_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic             add_start_q, add_start_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;

  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    winner_c;
  logic               found_c;
  logic [31:0]        a_arr [NUM_REQ];
  logic [31:0]        b_arr [NUM_REQ];
  logic [31:0]        win_a, win_b;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

  assign win_a = a_arr[winner_c];
  assign win_b = b_arr[winner_c];

`ifdef FP_SCHED_SPECIAL_BYPASS_EN
  // NaN in, or opposite infinities, give the canonical quiet NaN; otherwise the Inf operand (A first).
  function automatic logic [31:0] special_result(input logic [31:0] a, input logic [31:0] b);
    logic a_inf, b_inf, a_nan, b_nan;
    a_inf = (&a[30:23]) && (a[22:0] == 23'd0);
    b_inf = (&b[30:23]) && (b[22:0] == 23'd0);
    a_nan = (&a[30:23]) && (a[22:0] != 23'd0);
    b_nan = (&b[30:23]) && (b[22:0] != 23'd0);
    if (a_nan || b_nan)                        return 32'h7FC0_0000;
    else if (a_inf && b_inf && (a[31] != b[31])) return 32'h7FC0_0000;
    else if (a_inf)                            return a;
    else                                       return b;
  endfunction
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant_c  = '0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found_c && req_valid[ID_W'(idx)]) begin
        found_c              = 1'b1;
        grant_c[ID_W'(idx)]  = 1'b1;
        winner_c             = ID_W'(idx);
      end
    end
  end

  assign req_ready = (state_q == S_IDLE) ? grant_c : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          add_a_d   = win_a;
          add_b_d   = win_b;
          resp_id_d = winner_c;
          ptr_d     = winner_c;
          state_d   = S_ISSUE;
`ifdef FP_SCHED_SPECIAL_BYPASS_EN
          if ((&win_a[30:23]) || (&win_b[30:23])) begin
            resp_data_d = special_result(win_a, win_b);
            state_d     = S_RESP;
          end
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ADD_LATENCY - 1)) begin
          resp_data_d = add_result;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    add_start_d  = (state_d == S_ISSUE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      add_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      add_start_q  <= add_start_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign add_start  = add_start_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: transaction-level model of arbitration, latency and results.
module tb_fp_add_scheduler;
  localparam int NR = 4;
  localparam int L  = 3;
`ifdef FP_SCHED_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid, req_ready;
  logic [32*NR-1:0] req_a, req_b;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_data;
  logic [1:0]    resp_id;
  logic          add_start;
  logic [31:0]   add_a, add_b, add_result;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int ptr_m = NR - 1;
  logic [31:0] opa [NR];
  logic [31:0] opb [NR];
  logic [31:0] last_a = '0, last_b = '0;

  // Adder stand-in state
  int          stub_age = 0;
  bit          stub_on  = 1'b0;
  logic [31:0] stub_res = '0;

  fp_add_scheduler #(.NUM_REQ(NR), .ADD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .add_start(add_start),
    .add_a(add_a), .add_b(add_b), .add_result(add_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return (a + b) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] special_model(input logic [31:0] a, input logic [31:0] b);
    bit a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf && a[31] != b[31]) return 32'h7FC0_0000;
    if (a_inf) return a;
    return b;
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return BYPASS && ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF));
  endfunction

  function automatic int next_winner(input int ptr, input logic [NR-1:0] mask);
    for (int k = 1; k <= NR; k++)
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    return 0;
  endfunction

  // Result appears exactly L cycles after the add_start cycle; random junk otherwise.
  always @(negedge clk) begin
    if (add_start === 1'b1) begin
      stub_age = 0;
      stub_on  = 1'b1;
      stub_res = fadd_model(add_a, add_b);
    end else if (stub_on) begin
      stub_age++;
    end
    add_result = (stub_on && stub_age == L) ? stub_res : $urandom;
    if (stub_age >= L) stub_on = 1'b0;
  end

  task automatic pack_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[32*i +: 32] = opa[i];
      req_b[32*i +: 32] = opb[i];
    end
  endtask

  // One full transaction, entered at a negedge with the DUT idle; returns handshake cycle.
  task automatic run_op(input logic [NR-1:0] mask, input int bp, input bit rand_ops, output int hs);
    int w;
    logic [31:0] ea, eb, er;
    logic [NR-1:0] exp_rdy;
    bit byp;
    if (rand_ops)
      for (int i = 0; i < NR; i++) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
      end
    pack_ops();
    req_valid  = mask;
    resp_ready = 1'b0;
    #1;
    w       = next_winner(ptr_m, mask);
    exp_rdy = 4'b0001 << w;
    ea      = opa[w];
    eb      = opb[w];
    byp     = is_special(ea, eb);
    er      = byp ? special_model(ea, eb) : fadd_model(ea, eb);
    n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL grant got %b want %b", req_ready, exp_rdy); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL idle_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (add_a !== last_a || add_b !== last_b) begin n_bad++; $display("FAIL idle_hold_ops got %h/%h want %h/%h", add_a, add_b, last_a, last_b); end
    hs = cyc;
    @(posedge clk);
    ptr_m  = w;
    last_a = ea;
    last_b = eb;
    @(negedge clk);
    req_valid  = 4'($urandom);
    resp_ready = 1'($urandom);
    req_a      = {$urandom, $urandom, $urandom, $urandom};
    req_b      = {$urandom, $urandom, $urandom, $urandom};
    if (!byp) begin
      n_cmp++; if (add_start !== 1'b1) begin n_bad++; $display("FAIL issue_start got %b want 1", add_start); end
      n_cmp++; if (add_a !== ea || add_b !== eb) begin n_bad++; $display("FAIL issue_ops got %h/%h want %h/%h", add_a, add_b, ea, eb); end
      n_cmp++; if (req_ready !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL issue_ctl got rdy=%b busy=%b want 0/1", req_ready, busy); end
      for (int i = 0; i < L; i++) begin
        @(negedge clk);
        req_valid  = 4'($urandom);
        resp_ready = 1'($urandom);
        n_cmp++;
        if (add_start !== 1'b0 || resp_valid !== 1'b0 || req_ready !== '0 || add_a !== ea)
          begin n_bad++; $display("FAIL wait_%0d got start=%b rv=%b rdy=%b a=%h want 0/0/0/%h", i, add_start, resp_valid, req_ready, add_a, ea); end
      end
      @(negedge clk);
    end else begin
      n_cmp++; if (add_start !== 1'b0) begin n_bad++; $display("FAIL bypass_start got %b want 0", add_start); end
    end
    resp_ready = 1'b0;
    req_valid  = 4'($urandom);
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL resp_valid got %b want 1", resp_valid); end
    n_cmp++; if (resp_data !== er) begin n_bad++; $display("FAIL resp_data got %h want %h", resp_data, er); end
    n_cmp++; if (resp_id !== 2'(w)) begin n_bad++; $display("FAIL resp_id got %0d want %0d", resp_id, w); end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== er || resp_id !== 2'(w) || req_ready !== '0)
        begin n_bad++; $display("FAIL stall_%0d got rv=%b d=%h id=%0d rdy=%b want 1/%h/%0d/0", i, resp_valid, resp_data, resp_id, req_ready, er, w); end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== '0 ||
        add_start !== 1'b0 || add_a !== '0 || add_b !== '0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL reset_outputs got rdy=%b rv=%b d=%h id=%0d st=%b a=%h b=%h busy=%b want all 0", req_ready, resp_valid, resp_data, resp_id, add_start, add_a, add_b, busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int hs, prev;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      n_cmp++; if (next_winner(ptr_m, 4'hF) != order[n]) begin n_bad++; $display("FAIL rr_order_%0d got %0d want %0d", n, next_winner(ptr_m, 4'hF), order[n]); end
      run_op(4'hF, 0, 1'b1, hs);
      if (n > 0) begin
        n_cmp++; if (hs - prev != L + 3) begin n_bad++; $display("FAIL rr_spacing got %0d want %0d", hs - prev, L + 3); end
      end
      prev = hs;
    end
  endtask

  task automatic test_single();
    int hs;
    for (int i = 0; i < NR; i++) begin opa[i] = $urandom; opb[i] = $urandom; end
    opa[2] = 32'h3F80_0000; opb[2] = 32'h3F80_0000;
    run_op(4'b0100, 0, 1'b0, hs);
  endtask

  task automatic test_backpressure();
    int hs;
    run_op(4'b1010, 5, 1'b1, hs);
    run_op(4'b1111, 2, 1'b1, hs);
  endtask

  task automatic test_special();
    int hs;
    for (int i = 0; i < NR; i++) begin opa[i] = $urandom; opb[i] = $urandom; end
    opa[1] = 32'h7F80_0000; opb[1] = 32'hFF80_0000;
    run_op(4'b0010, 1, 1'b0, hs);
  endtask

  task automatic test_random();
    int hs;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b1, hs);
    end
  endtask

  task automatic test_mid_reset();
    int hs;
    for (int i = 0; i < NR; i++) begin opa[i] = $urandom; opb[i] = $urandom; end
    pack_ops();
    req_valid = 4'hF;
    @(posedge clk);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || add_start !== 1'b0 || resp_data !== '0 ||
        resp_id !== '0 || add_a !== '0 || add_b !== '0 || req_ready !== '0)
      begin n_bad++; $display("FAIL midreset_outputs got busy=%b rv=%b st=%b d=%h id=%0d a=%h want all 0", busy, resp_valid, add_start, resp_data, resp_id, add_a); end
    ptr_m = NR - 1; last_a = '0; last_b = '0;
    for (int i = 0; i < 4; i++) begin
      resp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_stale got %b want 0", resp_valid); end
    end
    resp_ready = 1'b0;
    n_cmp++; if (next_winner(ptr_m, 4'hF) != 0) begin n_bad++; $display("FAIL midreset_ptr got %0d want 0", next_winner(ptr_m, 4'hF)); end
    run_op(4'hF, 0, 1'b1, hs);
  endtask

  initial begin
    add_result = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_special();
    test_random();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
